// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic SYNC_RST  = 1'b1;  // line idles high, so the synchroniser resets to idle

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_START     = 3'd1;
    localparam state_t S_DATA      = 3'd2;
    localparam state_t S_STOP      = 3'd3;
    localparam state_t S_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock show-ahead FIFO; head word is presented combinationally, 0 when empty.
module rx_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO popped by rising edges of rx_fifo_read.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 434,
    parameter  int DEPTH        = 16,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          uart_rxd,
    input  logic          rx_fifo_read,
    input  logic          err_clear,
    output logic [7:0]    rx_char,
    output logic          rx_fifo_empty,
    output logic          rx_fifo_full,
    output logic [AW:0]   rx_count,
    output logic          rx_overrun,
    output logic          rx_framing_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    logic                 rxd_meta_q, rxd_s_q;
    logic                 rd_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 overrun_q, overrun_d;
    logic                 framing_q, framing_d;
    logic                 rd_edge, stop_ok, stop_bad, cnt_zero;

    assign rd_edge  = rx_fifo_read & ~rd_q;
    assign cnt_zero = (cnt_q == '0);
    assign stop_ok  = (state_q == S_STOP) & cnt_zero & rxd_s_q;
    assign stop_bad = (state_q == S_STOP) & cnt_zero & ~rxd_s_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    cnt_d   = HALF_BIT;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rxd_s_q) begin
                    cnt_d     = FULL_BIT;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d[bit_idx_q] = rxd_s_q;
                    cnt_d              = FULL_BIT;
                    bit_idx_d          = bit_idx_q + BW'(1);
                    if (bit_idx_q == BW'(DATA_BITS - 1)) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!cnt_zero)     cnt_d   = cnt_q - CW'(1);
                else if (rxd_s_q)  state_d = S_IDLE;
                else               state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must not look like a fresh start bit.
                if (rxd_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        overrun_d = err_clear ? 1'b0 : overrun_q;
        framing_d = err_clear ? 1'b0 : framing_q;
        // A full FIFO only drops the byte when no pop frees a slot this cycle.
        if (stop_ok && rx_fifo_full && !rd_edge) overrun_d = 1'b1;
        if (stop_bad) framing_d = 1'b1;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_meta_q <= SYNC_RST;
            rxd_s_q    <= SYNC_RST;
            rd_q       <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            overrun_q  <= 1'b0;
            framing_q  <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
            rd_q       <= rx_fifo_read;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            overrun_q  <= overrun_d;
            framing_q  <= framing_d;
        end
    end

    rx_sync_fifo #(.DEPTH(DEPTH), .W(DATA_BITS)) u_fifo (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .push          (stop_ok),
        .wdata         (shreg_q),
        .pop           (rd_edge),
        .rdata         (rx_char),
        .count         (rx_count),
        .full          (rx_fifo_full),
        .empty         (rx_fifo_empty)
    );

    assign rx_overrun     = overrun_q;
    assign rx_framing_err = framing_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=16, DEPTH=4.
module tb_uart_rx_fifo;
    import uart_rx_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       uart_rxd;
    logic       rx_fifo_read;
    logic       err_clear;
    logic [7:0] rx_char;
    logic       rx_fifo_empty, rx_fifo_full;
    logic [2:0] rx_count;
    logic       rx_overrun, rx_framing_err;

    int vectors = 0;
    int errs    = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .uart_rxd       (uart_rxd),
        .rx_fifo_read   (rx_fifo_read),
        .err_clear      (err_clear),
        .rx_char        (rx_char),
        .rx_fifo_empty  (rx_fifo_empty),
        .rx_fifo_full   (rx_fifo_full),
        .rx_count       (rx_count),
        .rx_overrun     (rx_overrun),
        .rx_framing_err (rx_framing_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every wait ends 1 time unit after a rising edge, so outputs are sampled off-edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cycles);
        uart_rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            cyc(CPB);
        end
        uart_rxd = stop;
        cyc(stop_cycles);
    endtask

    task automatic pop_one();
        rx_fifo_read = 1'b0;
        cyc(1);
        rx_fifo_read = 1'b1;
        cyc(1);
        rx_fifo_read = 1'b0;
    endtask

    task automatic chk_fifo(input string tag, input logic [7:0] ch, input logic [2:0] cnt,
                            input logic emp, input logic ful);
        chk({tag, ".char"},  32'(rx_char),       32'(ch));
        chk({tag, ".count"}, 32'(rx_count),      32'(cnt));
        chk({tag, ".empty"}, 32'(rx_fifo_empty), 32'(emp));
        chk({tag, ".full"},  32'(rx_fifo_full),  32'(ful));
    endtask

    initial begin
        reset_reset_n = 1'b0;
        uart_rxd      = 1'b1;
        rx_fifo_read  = 1'b0;
        err_clear     = 1'b0;
        cyc(3);
        chk_fifo("rst", 8'h00, 3'd0, 1'b1, 1'b0);
        chk("rst.ovr",   32'(rx_overrun),     32'(0));
        chk("rst.frm",   32'(rx_framing_err), 32'(0));
        chk("rst.state", 32'(dut.state_q),    32'(S_IDLE));
        reset_reset_n = 1'b1;
        cyc(3);

        // 1: push latency, byte appears one cycle after the stop sample
        send_frame(8'hA5, 1'b1, 10);
        chk("t1.pre_empty", 32'(rx_fifo_empty), 32'(1));
        cyc(1);
        chk_fifo("t1", 8'hA5, 3'd1, 1'b0, 1'b0);
        chk("t1.ovr", 32'(rx_overrun),     32'(0));
        chk("t1.frm", 32'(rx_framing_err), 32'(0));
        cyc(6);
        pop_one();
        chk_fifo("t1.drain", 8'h00, 3'd0, 1'b1, 1'b0);

        // 2: held read pops once; re-edge pops again; empty pop ignored
        send_frame(8'h31, 1'b1, CPB);
        send_frame(8'h32, 1'b1, CPB);
        send_frame(8'h33, 1'b1, CPB);
        chk_fifo("t2.fill", 8'h31, 3'd3, 1'b0, 1'b0);
        rx_fifo_read = 1'b1;
        cyc(5);
        chk_fifo("t2.hold", 8'h32, 3'd2, 1'b0, 1'b0);
        pop_one();
        chk_fifo("t2.repop", 8'h33, 3'd1, 1'b0, 1'b0);
        pop_one();
        chk_fifo("t2.last", 8'h00, 3'd0, 1'b1, 1'b0);
        pop_one();
        chk_fifo("t2.emptypop", 8'h00, 3'd0, 1'b1, 1'b0);

        // 3: overflow, then push coinciding with pop while full
        send_frame(8'h01, 1'b1, CPB);
        send_frame(8'h02, 1'b1, CPB);
        send_frame(8'h03, 1'b1, CPB);
        send_frame(8'h04, 1'b1, CPB);
        chk("t3.ovr_pre", 32'(rx_overrun), 32'(0));
        send_frame(8'h55, 1'b1, CPB);
        chk_fifo("t3.full", 8'h01, 3'd4, 1'b0, 1'b1);
        chk("t3.ovr", 32'(rx_overrun), 32'(1));
        send_frame(8'h66, 1'b1, 10);
        rx_fifo_read = 1'b1;
        cyc(1);
        chk_fifo("t3.pushpop", 8'h02, 3'd4, 1'b0, 1'b1);
        cyc(6);
        pop_one();
        pop_one();
        pop_one();
        chk_fifo("t3.tail", 8'h66, 3'd1, 1'b0, 1'b0);
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        chk("t3.clr", 32'(rx_overrun), 32'(0));
        pop_one();
        chk_fifo("t3.drain", 8'h00, 3'd0, 1'b1, 1'b0);

        // 4: framing error with a held-low stop, then recovery
        send_frame(8'h7E, 1'b0, 40);
        chk("t4.frm",   32'(rx_framing_err), 32'(1));
        chk("t4.count", 32'(rx_count),       32'(0));
        chk("t4.state", 32'(dut.state_q),    32'(S_WAIT_HIGH));
        uart_rxd = 1'b1;
        cyc(4);
        chk("t4.idle", 32'(dut.state_q), 32'(S_IDLE));
        send_frame(8'h12, 1'b1, CPB);
        chk_fifo("t4.rx", 8'h12, 3'd1, 1'b0, 1'b0);
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        chk("t4.clr", 32'(rx_framing_err), 32'(0));

        // 5: short low glitch returns to IDLE with no side effects
        uart_rxd = 1'b0;
        cyc(4);
        uart_rxd = 1'b1;
        chk("t5.start", 32'(dut.state_q), 32'(S_START));
        cyc(20);
        chk("t5.idle", 32'(dut.state_q), 32'(S_IDLE));
        chk_fifo("t5", 8'h12, 3'd1, 1'b0, 1'b0);
        chk("t5.ovr", 32'(rx_overrun),     32'(0));
        chk("t5.frm", 32'(rx_framing_err), 32'(0));

        // 6: reset during data bit 3 with two bytes queued
        pop_one();
        send_frame(8'hA1, 1'b1, CPB);
        send_frame(8'hB2, 1'b1, CPB);
        chk_fifo("t6.pre", 8'hA1, 3'd2, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        cyc(CPB);
        uart_rxd = 1'b1; cyc(CPB);
        uart_rxd = 1'b0; cyc(CPB);
        uart_rxd = 1'b1; cyc(CPB);
        uart_rxd = 1'b0;
        cyc(6);
        chk("t6.midframe", 32'(dut.state_q), 32'(S_DATA));
        reset_reset_n = 1'b0;
        #1;
        chk_fifo("t6.rst", 8'h00, 3'd0, 1'b1, 1'b0);
        chk("t6.ovr",   32'(rx_overrun),     32'(0));
        chk("t6.frm",   32'(rx_framing_err), 32'(0));
        chk("t6.state", 32'(dut.state_q),    32'(S_IDLE));
        uart_rxd = 1'b1;
        cyc(3);
        reset_reset_n = 1'b1;
        cyc(4);
        send_frame(8'hC3, 1'b1, CPB);
        chk_fifo("t6.rx", 8'hC3, 3'd1, 1'b0, 1'b0);
        chk("t6.frm_after", 32'(rx_framing_err), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
